deser_nx_param: RTL and testbench

Parametrised narrow-to-wide deserializer: packs RATIO consecutive IN_W-bit beats into one OUT_W = IN_W*RATIO word on the clk_4f domain. It is the generalised successor of the fixed 8-to-32 demux in the serial receive path. It adds:
- configurable lane order;
- explicit word alignment (sof_in);
- partial-word flush;
- gap-abort mode;
- a one-cycle word-valid pulse with a stable output holding register.

---
 rtl/deser_nx_param_if.sv | 29 ++
 rtl/deser_nx_param.sv | 99 +++++++++
 tb/tb_deser_nx_param.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/deser_nx_param_if.sv
// Beat-in / word-out bundle of the narrow-to-wide deserializer.
// The driver of beats uses master; the deserializer uses slave.
interface deser_nx_param_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic [IN_W-1:0]  data_in;
  logic             valid_in;
  logic             sof_in;
  logic             flush_in;
  logic [OUT_W-1:0] data_out;
  logic             valid_out;
  logic             partial_out;
  logic [CW-1:0]    lanes_out;
  logic             err_align;

  modport master (
    output data_in, valid_in, sof_in, flush_in,
    input  data_out, valid_out, partial_out, lanes_out, err_align
  );

  modport slave (
    input  data_in, valid_in, sof_in, flush_in,
    output data_out, valid_out, partial_out, lanes_out, err_align
  );
endinterface

// File: rtl/deser_nx_param.sv
// Packs RATIO consecutive IN_W-bit beats into one OUT_W-bit word, with
// sof alignment, partial flush, optional gap abort and a held output word.
module deser_nx_param #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 1,
  parameter int GAP_RESET = 0
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  deser_nx_param_if.slave  bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int CW    = $clog2(RATIO + 1);

  logic [CW-1:0]    r_idx;
  logic [OUT_W-1:0] r_asm;
  logic [OUT_W-1:0] r_dataOut;
  logic             r_validOut;
  logic             r_partialOut;
  logic [CW-1:0]    r_lanesOut;
  logic             r_errAlign;

  logic             w_sofBeat;
  logic [CW-1:0]    w_lane;
  logic [OUT_W-1:0] w_merged;
  logic [CW-1:0]    w_filled;
  logic             w_full;
  logic             w_flushEmit;
  logic             w_emit;
  logic             w_gapAbort;
  logic             w_sofAbort;

  // A qualified sof restarts assembly at lane 0 on a clean register, so the
  // merged word is built from either the held partial or from zero.
  always_comb begin
    w_sofBeat = bus.valid_in & bus.sof_in;
    w_lane    = w_sofBeat ? '0 : r_idx;
    w_merged  = w_sofBeat ? '0 : r_asm;
    if (bus.valid_in) begin
      for (int k = 0; k < RATIO; k++) begin
        if (w_lane == CW'(k)) begin
          if (MSB_FIRST != 0)
            w_merged[OUT_W-1-k*IN_W -: IN_W] = bus.data_in;
          else
            w_merged[k*IN_W +: IN_W] = bus.data_in;
        end
      end
    end
  end

  // Lanes occupied once this cycle's beat (if any) has landed; a flush is
  // judged against this count so that a flush on the last beat is a full word.
  always_comb begin
    w_filled = r_idx;
    if (bus.valid_in)
      w_filled = w_lane + CW'(1);
    w_full      = bus.valid_in && (w_filled == CW'(RATIO));
    w_flushEmit = bus.flush_in && (w_filled != '0) && (w_filled != CW'(RATIO));
    w_emit      = w_full || w_flushEmit;
    w_sofAbort  = w_sofBeat && (r_idx != '0);
    w_gapAbort  = (GAP_RESET != 0) && !bus.valid_in && !bus.flush_in &&
                  (r_idx != '0);
  end

  always_ff @(posedge clk_4f) begin
    if (!reset_L) begin
      r_idx        <= '0;
      r_asm        <= '0;
      r_dataOut    <= '0;
      r_validOut   <= 1'b0;
      r_partialOut <= 1'b0;
      r_lanesOut   <= '0;
      r_errAlign   <= 1'b0;
    end else begin
      r_validOut <= w_emit;
      r_errAlign <= w_sofAbort || w_gapAbort;
      if (w_emit) begin
        r_dataOut    <= w_merged;
        r_lanesOut   <= w_filled;
        r_partialOut <= !w_full;
        r_idx        <= '0;
        r_asm        <= '0;
      end else if (bus.valid_in) begin
        r_idx <= w_filled;
        r_asm <= w_merged;
      end else if (w_gapAbort) begin
        r_idx <= '0;
        r_asm <= '0;
      end
    end
  end

  assign bus.data_out    = r_dataOut;
  assign bus.valid_out   = r_validOut;
  assign bus.partial_out = r_partialOut;
  assign bus.lanes_out   = r_lanesOut;
  assign bus.err_align   = r_errAlign;
endmodule

// File: tb/tb_deser_nx_param.sv
// Directed bench: three deserializers (default, LSB-first, gap-abort) share
// one beat stream; expected words are hand-computed constants.
module tb_deser_nx_param;
  logic       clk_4f;
  logic       reset_L;
  logic [7:0] dIn;
  logic       vIn;
  logic       sIn;
  logic       fIn;
  int         total;
  int         bad;

  deser_nx_param_if #(.IN_W(8), .RATIO(4)) b0 ();
  deser_nx_param_if #(.IN_W(8), .RATIO(4)) b1 ();
  deser_nx_param_if #(.IN_W(8), .RATIO(4)) b2 ();

  assign b0.data_in = dIn;
  assign b0.valid_in = vIn;
  assign b0.sof_in = sIn;
  assign b0.flush_in = fIn;
  assign b1.data_in = dIn;
  assign b1.valid_in = vIn;
  assign b1.sof_in = sIn;
  assign b1.flush_in = fIn;
  assign b2.data_in = dIn;
  assign b2.valid_in = vIn;
  assign b2.sof_in = sIn;
  assign b2.flush_in = fIn;

  deser_nx_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .GAP_RESET(0)) u0 (
    .clk_4f(clk_4f), .reset_L(reset_L), .bus(b0));
  deser_nx_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(0), .GAP_RESET(0)) u1 (
    .clk_4f(clk_4f), .reset_L(reset_L), .bus(b1));
  deser_nx_param #(.IN_W(8), .RATIO(4), .MSB_FIRST(1), .GAP_RESET(1)) u2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .bus(b2));

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // One call = one rising edge; outputs are stable when it returns.
  task automatic applyStimulus(input logic [7:0] d, input logic v,
                               input logic s, input logic f);
    @(negedge clk_4f);
    dIn = d;
    vIn = v;
    sIn = s;
    fIn = f;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_L = 1'b0;
    dIn = 8'h00; vIn = 1'b0; sIn = 1'b0; fIn = 1'b0;
    applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_data", 64'(b0.data_out), 64'h0);
    checkOutput("rst_valid", 64'(b0.valid_out), 64'h0);
    checkOutput("rst_lanes", 64'(b0.lanes_out), 64'h0);
    checkOutput("rst_partial", 64'(b0.partial_out), 64'h0);
    checkOutput("rst_err", 64'(b0.err_align), 64'h0);
    reset_L = 1'b1;

    // full word, both lane orders
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hCC, 1'b1, 1'b0, 1'b0);
    checkOutput("full_novalid_early", 64'(b0.valid_out), 64'h0);
    applyStimulus(8'hDD, 1'b1, 1'b0, 1'b0);
    checkOutput("full_msb_data", 64'(b0.data_out), 64'hAABBCCDD);
    checkOutput("full_msb_valid", 64'(b0.valid_out), 64'h1);
    checkOutput("full_msb_lanes", 64'(b0.lanes_out), 64'h4);
    checkOutput("full_msb_partial", 64'(b0.partial_out), 64'h0);
    checkOutput("full_lsb_data", 64'(b1.data_out), 64'hDDCCBBAA);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("full_pulse_end", 64'(b0.valid_out), 64'h0);
    checkOutput("full_hold", 64'(b0.data_out), 64'hAABBCCDD);

    // back-to-back words
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(8'(i), 1'b1, 1'b0, 1'b0);
      if (i == 4) begin
        checkOutput("b2b_w1_data", 64'(b0.data_out), 64'h01020304);
        checkOutput("b2b_w1_valid", 64'(b0.valid_out), 64'h1);
      end
      if (i == 5 || i == 7) begin
        checkOutput("b2b_gap_valid", 64'(b0.valid_out), 64'h0);
        checkOutput("b2b_gap_hold", 64'(b0.data_out), 64'h01020304);
      end
    end
    checkOutput("b2b_w2_data", 64'(b0.data_out), 64'h05060708);
    checkOutput("b2b_w2_valid", 64'(b0.valid_out), 64'h1);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);

    // partial flush; the gap-abort instance must let flush win
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_data", 64'(b0.data_out), 64'h11220000);
    checkOutput("flush_valid", 64'(b0.valid_out), 64'h1);
    checkOutput("flush_lanes", 64'(b0.lanes_out), 64'h2);
    checkOutput("flush_partial", 64'(b0.partial_out), 64'h1);
    checkOutput("flush_lsb_data", 64'(b1.data_out), 64'h00002211);
    checkOutput("flush_gap_data", 64'(b2.data_out), 64'h11220000);
    checkOutput("flush_gap_err", 64'(b2.err_align), 64'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("flush_empty_valid", 64'(b0.valid_out), 64'h0);

    // sof realignment
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b1, 1'b0);
    checkOutput("sof_err", 64'(b0.err_align), 64'h1);
    checkOutput("sof_novalid", 64'(b0.valid_out), 64'h0);
    applyStimulus(8'h44, 1'b1, 1'b0, 1'b0);
    checkOutput("sof_err_end", 64'(b0.err_align), 64'h0);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h66, 1'b1, 1'b0, 1'b0);
    checkOutput("sof_word", 64'(b0.data_out), 64'h33445566);
    checkOutput("sof_word_valid", 64'(b0.valid_out), 64'h1);

    // idle mid-word: abort with GAP_RESET=1, hold otherwise
    applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("gap_err", 64'(b2.err_align), 64'h1);
    checkOutput("gap_hold_noerr", 64'(b0.err_align), 64'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
      if (i == 2)
        checkOutput("gap_hold_word", 64'(b0.data_out), 64'h11A0A1A2);
    end
    checkOutput("gap_word", 64'(b2.data_out), 64'hA0A1A2A3);
    checkOutput("gap_word_valid", 64'(b2.valid_out), 64'h1);
    checkOutput("gap_hold_after", 64'(b0.valid_out), 64'h0);

    // sof + valid + flush together (u0 holds A3, then BB -> 2 lanes)
    applyStimulus(8'hBB, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h5A, 1'b1, 1'b1, 1'b1);
    checkOutput("sofflush_err", 64'(b0.err_align), 64'h1);
    checkOutput("sofflush_valid", 64'(b0.valid_out), 64'h1);
    checkOutput("sofflush_data", 64'(b0.data_out), 64'h5A000000);
    checkOutput("sofflush_lanes", 64'(b0.lanes_out), 64'h1);
    checkOutput("sofflush_partial", 64'(b0.partial_out), 64'h1);
    checkOutput("sofflush_lsb", 64'(b1.data_out), 64'h0000005A);
    checkOutput("sofflush_gap_err", 64'(b2.err_align), 64'h1);

    // reset mid-word loses the partial silently
    applyStimulus(8'h01, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b1, 1'b0, 1'b0);
    reset_L = 1'b0;
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_data", 64'(b0.data_out), 64'h0);
    checkOutput("midrst_lanes", 64'(b0.lanes_out), 64'h0);
    checkOutput("midrst_partial", 64'(b0.partial_out), 64'h0);
    reset_L = 1'b1;
    applyStimulus(8'hC1, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_noerr", 64'(b0.err_align), 64'h0);
    applyStimulus(8'hC2, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hC4, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_word", 64'(b0.data_out), 64'hC1C2C3C4);
    checkOutput("midrst_valid", 64'(b0.valid_out), 64'h1);

    // flush on the last beat is an ordinary full word
    applyStimulus(8'h71, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h72, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h73, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h74, 1'b1, 1'b0, 1'b1);
    checkOutput("flushfull_data", 64'(b0.data_out), 64'h71727374);
    checkOutput("flushfull_lanes", 64'(b0.lanes_out), 64'h4);
    checkOutput("flushfull_partial", 64'(b0.partial_out), 64'h0);
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("flushfull_pulse_end", 64'(b0.valid_out), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
